uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 126 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a small byte FIFO.
// Back-to-back frames chain from the last stop-bit cycle straight into the next start bit.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DEPTH_LOG2   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [7:0]            wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic                  tx,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = 12;
  localparam logic [TW-1:0]         T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [DEPTH_LOG2:0]   FULL_N = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_nxt;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0]         timer, timer_nxt;
  logic [2:0]            bit_idx, bit_idx_nxt;
  logic [7:0]            shreg, shreg_nxt;
  logic                  tx_nxt, push, pop, full, has_data, bit_end, can_start;

  assign full      = (fifo_count == FULL_N);
  assign has_data  = (fifo_count != '0);
  assign wr_ready  = ~full;
  assign push      = wr_valid & ~full;
  assign busy      = (state != IDLE) | has_data;
  assign bit_end   = (timer == T_LAST);
  assign can_start = ena & has_data;

  // FIFO storage carries no reset; only pointers and count define contents.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
      if (wr_valid && full)  overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
      tx      <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer + 1'b1;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    tx_nxt      = tx;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (can_start) begin
          pop       = 1'b1;
          state_nxt = START;
          shreg_nxt = mem[rd_ptr];
          tx_nxt    = 1'b0;
        end
      end
      START: if (bit_end) begin
        state_nxt   = DATA;
        timer_nxt   = '0;
        bit_idx_nxt = '0;
        tx_nxt      = shreg[0];
      end
      DATA: if (bit_end) begin
        timer_nxt = '0;
        if (bit_idx == 3'd7) begin
          state_nxt = STOP;
          tx_nxt    = 1'b1;
        end else begin
          bit_idx_nxt = bit_idx + 1'b1;
          shreg_nxt   = {1'b0, shreg[7:1]};
          tx_nxt      = shreg[1];
        end
      end
      STOP: if (bit_end) begin
        timer_nxt = '0;
        // Chain directly into the next start bit so frames have no idle gap.
        if (can_start) begin
          pop       = 1'b1;
          state_nxt = START;
          shreg_nxt = mem[rd_ptr];
          tx_nxt    = 1'b0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a tx-line monitor decodes frames and pops expected bytes.
module tb_uart_tx_fifo;
  localparam int C  = 4;
  localparam int DL = 2;

  logic          clk = 1'b0, rst = 1'b1, ena = 1'b0, wr_valid = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          wr_ready, tx, busy, overflow;
  logic [DL:0]   fifo_count;

  int            total = 0, bad = 0;
  int            cyc = 0;
  int            frames_seen = 0;
  int            start_q[$];
  logic [7:0]    exp_q[$];

  uart_tx_fifo #(.CLKS_PER_BIT(C), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst), .ena(ena), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every bit must hold for exactly C samples; a reset inside a frame abandons it.
  initial begin : monitor
    logic [9:0] bits;
    logic [7:0] exp_b;
    logic       width_ok, aborted;
    int         st;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        st = cyc; width_ok = 1'b1; aborted = 1'b0; bits = '0;
        for (int b = 0; b < 10 && !aborted; b++) begin
          for (int c = 0; c < C && !aborted; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rst) aborted = 1'b1;
            else if (c == 0) bits[b] = tx;
            else if (tx !== bits[b]) width_ok = 1'b0;
          end
        end
        if (!aborted) begin
          start_q.push_back(st);
          frames_seen++;
          total++;
          if (!width_ok || bits[0] !== 1'b0 || bits[9] !== 1'b1) begin
            bad++;
            $display("FAIL frame_timing got bits=%b steady=%0d req start=0 stop=1 steady=1", bits, width_ok);
          end
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL frame_data got=%h req=no frame", bits[8:1]);
          end else begin
            exp_b = exp_q.pop_front();
            if (bits[8:1] !== exp_b) begin
              bad++;
              $display("FAIL frame_data got=%h req=%h", bits[8:1], exp_b);
            end
          end
        end
      end
    end
  end

  task automatic do_reset();
    wr_valid = 1'b0; ena = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic wait_frames(input int target, input int limit, output bit ok);
    int t = 0;
    while (frames_seen < target && t < limit) begin
      @(posedge clk);
      t++;
    end
    ok = (frames_seen >= target);
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; wr_valid = 1'b1; wr_data = 8'h5A;
    repeat (6) @(posedge clk); #1;
    total++; if (tx !== 1'b1)         begin bad++; $display("FAIL rst_tx got=%b req=1", tx); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d req=0", fifo_count); end
    total++; if (wr_ready !== 1'b1)   begin bad++; $display("FAIL rst_wr_ready got=%b req=1", wr_ready); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy got=%b req=0", busy); end
    total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL rst_overflow got=%b req=0", overflow); end
    rst = 1'b0; wr_valid = 1'b0; ena = 1'b0;
    @(posedge clk); #1;
    total++; if (fifo_count !== 3'd0 || overflow !== 1'b0)
      begin bad++; $display("FAIL rst_write_ignored got count=%0d ovf=%b req 0 0", fifo_count, overflow); end
  endtask

  task automatic test_single();
    bit ok;
    int base;
    do_reset();
    ena = 1'b1; base = frames_seen;
    exp_q.push_back(8'hA5);
    wr_valid = 1'b1; wr_data = 8'hA5;
    @(posedge clk); #1; wr_valid = 1'b0;
    total++; if (fifo_count !== 3'd1 || tx !== 1'b1)
      begin bad++; $display("FAIL single_queued got count=%0d tx=%b req 1 1", fifo_count, tx); end
    @(posedge clk); #1;
    total++; if (tx !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b1)
      begin bad++; $display("FAIL single_latency got tx=%b count=%0d busy=%b req 0 0 1", tx, fifo_count, busy); end
    wait_frames(base + 1, 60, ok);
    #1;
    total++; if (!ok) begin bad++; $display("FAIL single_timeout got frames=%0d req=%0d", frames_seen, base + 1); end
    total++; if (busy !== 1'b0 || tx !== 1'b1)
      begin bad++; $display("FAIL single_end got busy=%b tx=%b req 0 1", busy, tx); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int base, peak;
    do_reset();
    ena = 1'b1; base = frames_seen; peak = 0;
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    wr_valid = 1'b1; wr_data = 8'h00;
    @(negedge clk); if (int'(fifo_count) > peak) peak = int'(fifo_count);
    @(posedge clk); #1; wr_data = 8'hFF;
    @(negedge clk); if (int'(fifo_count) > peak) peak = int'(fifo_count);
    @(posedge clk); #1; wr_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    total++; if (peak != 1) begin bad++; $display("FAIL b2b_peak got=%0d req=1", peak); end
    wait_frames(base + 2, 120, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_timeout got frames=%0d req=%0d", frames_seen, base + 2); end
    else begin
      total++;
      if (start_q[$] - start_q[$-1] != 10 * C)
        begin bad++; $display("FAIL b2b_gap got=%0d req=%0d", start_q[$] - start_q[$-1], 10 * C); end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    int base;
    do_reset();
    base = frames_seen;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_data = 8'h11 + 8'(i);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d req=4", fifo_count); end
    total++; if (wr_ready !== 1'b0)   begin bad++; $display("FAIL ovf_wr_ready got=%b req=0", wr_ready); end
    total++; if (overflow !== 1'b1)   begin bad++; $display("FAIL ovf_flag got=%b req=1", overflow); end
    total++; if (tx !== 1'b1)         begin bad++; $display("FAIL ovf_idle_tx got=%b req=1", tx); end
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h11 + 8'(i));
    ena = 1'b1;
    wait_frames(base + 4, 250, ok);
    total++; if (!ok || exp_q.size() != 0)
      begin bad++; $display("FAIL ovf_drain got frames=%0d left=%0d req %0d 0", frames_seen - base, exp_q.size(), 4); end
    repeat (60) @(posedge clk); #1;
    total++; if (frames_seen != base + 4 || busy !== 1'b0)
      begin bad++; $display("FAIL ovf_no_extra got frames=%0d busy=%b req 4 0", frames_seen - base, busy); end
  endtask

  task automatic test_ena_gating();
    bit ok;
    int base, lows;
    do_reset();
    ena = 1'b1; base = frames_seen; lows = 0;
    exp_q.push_back(8'h3C); exp_q.push_back(8'hC3);
    wr_valid = 1'b1; wr_data = 8'h3C;
    @(posedge clk); #1; wr_data = 8'hC3;
    @(posedge clk); #1; wr_valid = 1'b0;
    repeat (17) @(posedge clk); #1;
    ena = 1'b0;
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL gate_queued got=%0d req=1", fifo_count); end
    wait_frames(base + 1, 60, ok);
    total++; if (!ok) begin bad++; $display("FAIL gate_frame_timeout got frames=%0d req=%0d", frames_seen - base, 1); end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) lows++;
    end
    total++; if (lows != 0 || fifo_count !== 3'd1)
      begin bad++; $display("FAIL gate_hold got lows=%0d count=%0d req 0 1", lows, fifo_count); end
    ena = 1'b1;
    @(posedge clk); #1;
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL gate_resume got tx=%b req=0", tx); end
    wait_frames(base + 2, 60, ok);
    total++; if (!ok) begin bad++; $display("FAIL gate_second_timeout got frames=%0d req=%0d", frames_seen - base, 2); end
  endtask

  task automatic test_reset_mid();
    int base, lows;
    do_reset();
    ena = 1'b1; base = frames_seen; lows = 0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = 8'h55 + 8'(i * 17);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    repeat (6) @(posedge clk); #1;
    total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL rmid_queued got=%0d req=2", fifo_count); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    total++; if (tx !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0)
      begin bad++; $display("FAIL rmid_state got tx=%b count=%0d busy=%b req 1 0 0", tx, fifo_count, busy); end
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) lows++;
    end
    total++; if (lows != 0 || frames_seen != base)
      begin bad++; $display("FAIL rmid_quiet got lows=%0d frames=%0d req 0 0", lows, frames_seen - base); end
  endtask

  task automatic test_push_pop();
    bit ok;
    int base;
    do_reset();
    base = frames_seen;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = 8'h21 + 8'(i);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    total++; if (wr_ready !== 1'b0 || overflow !== 1'b0)
      begin bad++; $display("FAIL pp_full got wr_ready=%b ovf=%b req 0 0", wr_ready, overflow); end
    ena = 1'b1; wr_valid = 1'b1; wr_data = 8'h99;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    total++; if (overflow !== 1'b1 || fifo_count !== 3'd3 || tx !== 1'b0)
      begin bad++; $display("FAIL pp_reject got ovf=%b count=%0d tx=%b req 1 3 0", overflow, fifo_count, tx); end
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h21 + 8'(i));
    wait_frames(base + 4, 250, ok);
    total++; if (!ok || exp_q.size() != 0)
      begin bad++; $display("FAIL pp_drain got frames=%0d left=%0d req 4 0", frames_seen - base, exp_q.size()); end
    repeat (60) @(posedge clk); #1;
    total++; if (frames_seen != base + 4)
      begin bad++; $display("FAIL pp_no_extra got frames=%0d req=4", frames_seen - base); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_ena_gating();
    test_reset_mid();
    test_push_pop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
